sync_fifo: RTL and testbench

Single-clock FIFO, 32 entries x 16 bits by default. It sits downstream of the counter blocks and buffers their sampled count values, or any 16-bit producer's data, for a consumer that drains at its own pace. It uses a valid-qualified registered read port with full, empty, almost-full and almost-empty status and an occupancy count.

---
 rtl/sync_fifo.sv | 140 ++++++++++++++
 tb/tb_sync_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO (DEPTH x DATA_W) with full/empty/almost flags and occupancy count.
// Latency: write-to-readable 1 cycle; rd_data/rd_valid registered, one cycle after rd_en is sampled.
// Backpressure: writes while full (no rd_en) and reads while empty are dropped; optional
// sticky overflow/underflow outputs enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the low address bits coincide.
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_LEVEL);

  // Storage is deliberately not reset; the pointers alone define validity.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              full_w;
  logic              empty_w;
  logic [ADDR_W:0]   count_w;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Status derived only from registered pointers: no path from wr_en/rd_en.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count_w = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is still taken when a read frees the oldest
  // slot on the same edge. A read from empty is never taken, so there is
  // no fall-through of the word being written.
  assign wr_acc = wr_en && (!full_w || rd_en);
  assign rd_acc = rd_en && !empty_w;

  // Next-state for pointers and the registered read port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      // mem still holds pre-edge contents here, so a full-FIFO read+write
      // to the same address returns the old (oldest) word.
      rd_data_d = mem[rd_addr];
    end
  end

  // Pointer and read-port registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage write on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign count        = count_w;
  assign almost_full  = (count_w >= AF_LVL);
  assign almost_empty = (count_w <= AE_LVL);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; only reset clears them.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en && full_w && !rd_en);
    underflow_d = underflow_q | (rd_en && empty_w);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + randomized stimulus for sync_fifo, checked against a queue model.
// Latency: model predicts registered read port one cycle after rd_en is sampled.
// Backpressure: model drops writes when full without read and reads when empty.
module tb_sync_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int AF = 28;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of stored words plus the expected read port.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r);
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (w && was_full && !r) m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    m_rd_valid = 1'b0;
    if (r && !was_empty) begin
      m_rd_data  = mq.pop_front();
      m_rd_valid = 1'b1;
    end
    if (w && (!was_full || r)) mq.push_back(d);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(m_rd_data));
    chk({tag, ".count"},    32'(count),    32'(n));
    chk({tag, ".empty"},    32'(empty),    32'(n == 0));
    chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
    chk({tag, ".afull"},    32'(almost_full),  32'(n >= AF));
    chk({tag, ".aempty"},   32'(almost_empty), 32'(n <= AE));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  // One clock: drive at the negative edge, update model at the rising edge,
  // compare at the following negative edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    model_edge(w, d, r);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_outputs("por");

    // Load some data, then assert reset mid-cycle away from any edge.
    for (int i = 0; i < 3; i++) step("preload", 1'b1, 16'h5A00 + 16'(i), 1'b0);
    step("preload_rd", 1'b0, '0, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    chk("rst_async.rd_data0", 32'(rd_data), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    // Buffered data was discarded: a read now returns nothing.
    step("post_rst_rd", 1'b0, '0, 1'b1);
    chk("post_rst_rd.valid", 32'(rd_valid), 32'h0);
    chk("post_rst_rd.data", 32'(rd_data), 32'h0);

    // Fill with 0x0000..0x001F.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 16'(i), 1'b0);
      if (i == 4) chk("fill.aempty_at5", 32'(almost_empty), 32'h0);
      if (i == 26) chk("fill.afull_at27", 32'(almost_full), 32'h0);
      if (i == 27) chk("fill.afull_at28", 32'(almost_full), 32'h1);
    end
    chk("fill.full", 32'(full), 32'h1);
    chk("fill.count32", 32'(count), 32'd32);

    // Write while full without a read is dropped.
    step("ovf_drop", 1'b1, 16'hDEAD, 1'b0);
    chk("ovf_drop.count", 32'(count), 32'd32);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_drop.flag", 32'(overflow), 32'h1);
    step("ovf_sticky", 1'b0, '0, 1'b0);
    chk("ovf_sticky.flag", 32'(overflow), 32'h1);
`endif

    // Simultaneous read+write while full: read-before-write.
    step("full_rw", 1'b1, 16'hBEEF, 1'b1);
    chk("full_rw.data", 32'(rd_data), 32'h0000);
    chk("full_rw.count", 32'(count), 32'd32);
    for (int i = 1; i < DEPTH; i++) begin
      step("drain", 1'b0, '0, 1'b1);
      chk("drain.seq", 32'(rd_data), 32'(i));
    end
    step("drain_last", 1'b0, '0, 1'b1);
    chk("drain_last.data", 32'(rd_data), 32'hBEEF);
    chk("drain_last.empty", 32'(empty), 32'h1);
    step("unf_rd", 1'b0, '0, 1'b1);
    chk("unf_rd.data", 32'(rd_data), 32'hBEEF);
    chk("unf_rd.valid", 32'(rd_valid), 32'h0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf_rd.flag", 32'(underflow), 32'h1);
`endif

    // Streaming across several pointer wraps.
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b1, 16'h1000 + 16'(i), mq.size() >= 3);
      chk("stream.cnt_le4", 32'(count <= 4), 32'h1);
    end
    while (mq.size() > 0) step("stream_drain", 1'b0, '0, 1'b1);

    // From empty: simultaneous read+write takes only the write.
    step("empty_rw", 1'b1, 16'h00AA, 1'b1);
    chk("empty_rw.count", 32'(count), 32'd1);
    chk("empty_rw.valid", 32'(rd_valid), 32'h0);
    step("empty_rw_rd", 1'b0, '0, 1'b1);
    chk("empty_rw_rd.data", 32'(rd_data), 32'h00AA);
    chk("empty_rw_rd.valid", 32'(rd_valid), 32'h1);

    // Randomized traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      int rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 80; i++) begin
        logic w;
        logic r;
        w = ($urandom_range(99) < wp);
        r = ($urandom_range(99) < rp);
        step("rand", w, 16'($urandom), r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
